// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive path.
//   rx_state_t  : receiver FSM states
//   DATA_BITS   : payload bits per frame
//   IDLE_LEVEL  : line level while idle, and the stop bit
//   START_LEVEL : start-bit level
//   tick_div()  : system clocks per oversample tick (truncated)
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int   DATA_BITS   = 8;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Truncating division. At 100 MHz / (115200 * 16) this gives 54.
  function automatic int tick_div(input int clk_freq, input int baud,
                                  input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage : uart_pkg

// File: rtl/uart_rx_tick.sv
// -----------------------------------------------------------------------------
// uart_rx_tick
// Oversample tick generator for the receiver. Counts 0..TICK_DIV-1 while en is
// high and emits a one-cycle tick on the wrap. While en is low the counter is
// cleared, so the first tick always lands TICK_DIV cycles after en rises.
// Independent of any transmitter baud generator.
// Ports:
//   clock : system clock
//   reset : synchronous, active-high
//   en    : count enable; low holds the counter at 0
//   tick  : one-cycle pulse every TICK_DIV enabled cycles
// -----------------------------------------------------------------------------
module uart_rx_tick #(
  parameter int TICK_DIV = 54
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop sees
  // the pre-edge value of every other flop, matching real hardware.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == CNT_LAST);

endmodule : uart_rx_tick

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// Serial-to-parallel UART receive path with 16x oversampling and mid-bit
// sampling. Frame is 8N1 by default; defining RX_PARITY_EN makes it 8E1
// (even parity checked, mismatch reported as a frame error).
// Ports:
//   clock         : system clock, rising edge
//   reset         : synchronous, active-high
//   RxD           : asynchronous serial input, idles high
//   RxD_data[7:0] : last good byte; held until the next good frame
//   RxD_valid     : one-cycle pulse when RxD_data is updated
//   RxD_busy      : high from start detection to the stop-bit sample
//   RxD_frame_err : one-cycle pulse on bad stop bit (or parity mismatch)
// Configuration macro: RX_PARITY_EN
// -----------------------------------------------------------------------------
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 RxD,
  output logic [DATA_BITS-1:0] RxD_data,
  output logic                 RxD_valid,
  output logic                 RxD_busy,
  output logic                 RxD_frame_err
);

  localparam int TICK_DIV = tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SAMPLE_W = $clog2(OVERSAMPLE);
  localparam int IDX_W    = $clog2(DATA_BITS);

  localparam logic [SAMPLE_W-1:0] MID_LAST = SAMPLE_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMPLE_W-1:0] BIT_LAST = SAMPLE_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(DATA_BITS - 1);

  // Two-flop synchronizer; only rx_s_q is used for decisions.
  logic rx_meta_q, rx_s_q;

  rx_state_t            state_q, state_d;
  logic [SAMPLE_W-1:0]  sample_cnt_q, sample_cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err;

  logic tick;
  logic start_det;
  logic stop_sample;
  logic stop_ok;

  // A start is only recognised once the idle line has been seen high, so a
  // line stuck low after a framing error does not retrigger.
  assign start_det = (state_q == IDLE) && armed_q && (rx_s_q == START_LEVEL);

  uart_rx_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .en   ((state_q != IDLE) || start_det),
    .tick (tick)
  );

`ifdef RX_PARITY_EN
  logic parity_err_q, parity_err_d;
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_q    <= IDLE_LEVEL;
      rx_s_q       <= IDLE_LEVEL;
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      armed_q      <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= RxD;
      rx_s_q       <= rx_meta_q;
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      armed_q      <= armed_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      frame_err_q  <= frame_err_d;
`ifdef RX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    armed_d      = armed_q;
`ifdef RX_PARITY_EN
    parity_err_d = parity_err_q;
`endif

    case (state_q)
      IDLE: begin
        sample_cnt_d = '0;
        if (rx_s_q == IDLE_LEVEL) begin
          armed_d = 1'b1;
        end
        if (start_det) begin
          state_d = START;
        end
      end

      START: begin
        if (tick) begin
          if (sample_cnt_q == MID_LAST) begin
            sample_cnt_d = '0;
            if (rx_s_q == IDLE_LEVEL) begin
              // Line went back high before mid start bit: glitch.
              state_d = IDLE;
              armed_d = 1'b0;
            end else begin
              state_d   = DATA;
              bit_idx_d = '0;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (sample_cnt_q == BIT_LAST) begin
            sample_cnt_d = '0;
            // Right shift: first (LSB) bit ends up in shreg[0].
            shreg_d   = {rx_s_q, shreg_q[DATA_BITS-1:1]};
            bit_idx_d = bit_idx_q + 1'b1;
            if (bit_idx_q == IDX_LAST) begin
`ifdef RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            sample_cnt_d = sample_cnt_q + 1'b1;
          end
        end
      end

`ifdef RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (sample_cnt_q == BIT_LAST) begin
            sample_cnt_d = '0;
            // Even parity: the parity bit must equal the XOR of the data.
            parity_err_d = (rx_s_q != ^shreg_q);
            state_d      = STOP;
          end else begin
            sample_cnt_d = sample_cnt_q + 1'b1;
          end
        end
      end
`endif

      STOP: begin
        if (tick) begin
          if (sample_cnt_q == BIT_LAST) begin
            // Back to IDLE at mid stop bit so a following start edge is seen.
            sample_cnt_d = '0;
            state_d      = IDLE;
            armed_d      = 1'b0;
          end else begin
            sample_cnt_d = sample_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        armed_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  assign stop_sample = (state_q == STOP) && tick && (sample_cnt_q == BIT_LAST);
  assign stop_ok     = (rx_s_q == IDLE_LEVEL) && !parity_err;

  always_comb begin
    valid_d     = stop_sample && stop_ok;
    frame_err_d = stop_sample && !stop_ok;
    data_d      = valid_d ? shreg_q : data_q;
    busy_d      = (state_d != IDLE);
  end

  assign RxD_data      = data_q;
  assign RxD_valid     = valid_q;
  assign RxD_busy      = busy_q;
  assign RxD_frame_err = frame_err_q;

endmodule : uart_receiver

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
// Directed bench for uart_receiver at default parameters (1 bit = 864 clocks).
// Define RX_PARITY_EN for both files to exercise the 8E1 build.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

  localparam int BIT = 864;

  logic       clock = 1'b0;
  logic       reset;
  logic       RxD;
  logic [7:0] RxD_data;
  logic       RxD_valid;
  logic       RxD_busy;
  logic       RxD_frame_err;

  always #5 clock = ~clock;

  uart_receiver dut (
    .clock        (clock),
    .reset        (reset),
    .RxD          (RxD),
    .RxD_data     (RxD_data),
    .RxD_valid    (RxD_valid),
    .RxD_busy     (RxD_busy),
    .RxD_frame_err(RxD_frame_err)
  );

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every high cycle of a strobe is recorded, so a stretched pulse
  // shows up as an extra entry.
  logic [7:0]  rx_bytes[$];
  int unsigned rx_cyc[$];
  int          ferr_cnt = 0;

  always @(negedge clock) begin
    if (!reset) begin
      if (RxD_valid) begin
        rx_bytes.push_back(RxD_data);
        rx_cyc.push_back(cyc);
      end
      if (RxD_frame_err) ferr_cnt++;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_bits(input int n);
    repeat (n * BIT) @(negedge clock);
  endtask

  // Drives one frame; the line is left at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop_lvl,
                            input logic par_bit);
    RxD = 1'b0;
    repeat (BIT) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      repeat (BIT) @(negedge clock);
    end
`ifdef RX_PARITY_EN
    RxD = par_bit;
    repeat (BIT) @(negedge clock);
`endif
    RxD = stop_lvl;
    repeat (BIT) @(negedge clock);
  endtask

  int n0;
  int f0;

  initial begin
    reset = 1'b1;
    RxD   = 1'b1;
    repeat (5) @(negedge clock);
    check("reset_data",  32'(RxD_data), 32'h00);
    check("reset_valid", 32'(RxD_valid), 32'h0);
    check("reset_busy",  32'(RxD_busy), 32'h0);
    check("reset_ferr",  32'(RxD_frame_err), 32'h0);
    reset = 1'b0;

    // 1. Idle line
    wait_bits(10);
    check("idle_busy",  32'(RxD_busy), 32'h0);
    check("idle_valid", 32'(rx_bytes.size()), 32'd0);
    check("idle_ferr",  32'(ferr_cnt), 32'd0);

    // 2. Single byte 0xA5
    n0 = rx_bytes.size();
    f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, ^8'hA5);
    wait_bits(1);
    check("a5_count", 32'(rx_bytes.size() - n0), 32'd1);
    check("a5_byte",  32'(rx_bytes[n0]), 32'hA5);
    check("a5_data",  32'(RxD_data), 32'hA5);
    check("a5_busy",  32'(RxD_busy), 32'h0);
    check("a5_ferr",  32'(ferr_cnt - f0), 32'd0);

    // 3. Back-to-back 0x00, 0xFF with no idle time
    n0 = rx_bytes.size();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    wait_bits(1);
    check("b2b_count", 32'(rx_bytes.size() - n0), 32'd2);
    check("b2b_first", 32'(rx_bytes[n0]), 32'h00);
    check("b2b_second", 32'(rx_bytes[n0+1]), 32'hFF);
`ifdef RX_PARITY_EN
    check("b2b_spacing", rx_cyc[n0+1] - rx_cyc[n0], 32'(11 * BIT));
`else
    check("b2b_spacing", rx_cyc[n0+1] - rx_cyc[n0], 32'(10 * BIT));
`endif

    // 4. 300-clock glitch
    n0 = rx_bytes.size();
    f0 = ferr_cnt;
    RxD = 1'b0;
    repeat (100) @(negedge clock);
    check("glitch_busy_hi", 32'(RxD_busy), 32'h1);
    repeat (200) @(negedge clock);
    RxD = 1'b1;
    wait_bits(2);
    check("glitch_busy_lo", 32'(RxD_busy), 32'h0);
    check("glitch_valid", 32'(rx_bytes.size() - n0), 32'd0);
    check("glitch_ferr",  32'(ferr_cnt - f0), 32'd0);

    // 5. Bad stop bit, line then stuck low for another bit
    n0 = rx_bytes.size();
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, ^8'h3C);
    wait_bits(1);
    RxD = 1'b1;
    wait_bits(2);
    check("ferr_count", 32'(ferr_cnt - f0), 32'd1);
    check("ferr_valid", 32'(rx_bytes.size() - n0), 32'd0);
    check("ferr_data_held", 32'(RxD_data), 32'hFF);
    check("ferr_busy", 32'(RxD_busy), 32'h0);

    // 6. Reset during data bit 4, then a clean 0x5A
    n0 = rx_bytes.size();
    f0 = ferr_cnt;
    fork
      send_frame(8'hF0, 1'b1, ^8'hF0);
      begin
        repeat (5 * BIT + BIT / 2) @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        check("rst_mid_data", 32'(RxD_data), 32'h00);
        check("rst_mid_busy", 32'(RxD_busy), 32'h0);
        reset = 1'b0;
      end
    join
    wait_bits(2);
    check("abort_valid", 32'(rx_bytes.size() - n0), 32'd0);
    check("abort_ferr",  32'(ferr_cnt - f0), 32'd0);
    send_frame(8'h5A, 1'b1, ^8'h5A);
    wait_bits(1);
    check("5a_count", 32'(rx_bytes.size() - n0), 32'd1);
    check("5a_byte",  32'(rx_bytes[n0]), 32'h5A);
    check("5a_data",  32'(RxD_data), 32'h5A);

`ifdef RX_PARITY_EN
    // Parity: 0x07 has three ones, so the even-parity bit is 1.
    n0 = rx_bytes.size();
    f0 = ferr_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    wait_bits(1);
    check("par_ok_count", 32'(rx_bytes.size() - n0), 32'd1);
    check("par_ok_byte",  32'(rx_bytes[n0]), 32'h07);
    check("par_ok_ferr",  32'(ferr_cnt - f0), 32'd0);
    n0 = rx_bytes.size();
    send_frame(8'h07, 1'b1, 1'b0);
    wait_bits(1);
    check("par_bad_count", 32'(rx_bytes.size() - n0), 32'd0);
    check("par_bad_ferr",  32'(ferr_cnt - f0), 32'd1);
    check("par_bad_data",  32'(RxD_data), 32'h07);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_receiver
